// File: rtl/wb_regfile.sv
// wb_regfile: MIPS write-back result select and 32-entry register file.
// Optional `REGFILE_BYPASS_EN: same-cycle write-to-read bypass on RD1/RD2.
module wb_regfile #(
  parameter int size = 31
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          RegWriteW,
  input  logic          MemtoRegW,
  input  logic [size:0] ReadDataW,
  input  logic [size:0] ALUOutW,
  input  logic [4:0]    WriteRegW,
  input  logic [4:0]    A1,
  input  logic [4:0]    A2,
  input  logic [4:0]    A3,
  output logic [size:0] RD1,
  output logic [size:0] RD2,
  output logic [size:0] RD3,
  output logic [size:0] ResultW,
  output logic [31:0]   WriteCount
);

  logic [size:0] regs [32];
  logic [31:0]   write_count;
  logic          commit;

  assign ResultW    = MemtoRegW ? ReadDataW : ALUOutW;
  assign WriteCount = write_count;

  // rst_n gate keeps the bypass path quiet while in reset
  assign commit = rst_n && RegWriteW && (WriteRegW != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
      write_count <= '0;
    end else if (commit) begin
      regs[WriteRegW] <= ResultW;
      write_count     <= write_count + 32'd1;
    end
  end

  always_comb begin
    RD1 = (A1 == 5'd0) ? '0 : regs[A1];
    RD2 = (A2 == 5'd0) ? '0 : regs[A2];
    RD3 = (A3 == 5'd0) ? '0 : regs[A3];
`ifdef REGFILE_BYPASS_EN
    if (commit && (A1 == WriteRegW)) begin
      RD1 = ResultW;
    end
    if (commit && (A2 == WriteRegW)) begin
      RD2 = ResultW;
    end
`endif
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: vector table, hand sequences and random run
// against an array-based reference model of wb_regfile.
module tb_wb_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        we;
  logic        mtr;
  logic [31:0] rdata;
  logic [31:0] alu;
  logic [4:0]  wr;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [4:0]  a3;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] rd3;
  logic [31:0] result;
  logic [31:0] count;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_reg [32];
  logic [31:0] m_cnt;

  wb_regfile #(.size(31)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RegWriteW  (we),
    .MemtoRegW  (mtr),
    .ReadDataW  (rdata),
    .ALUOutW    (alu),
    .WriteRegW  (wr),
    .A1         (a1),
    .A2         (a2),
    .A3         (a3),
    .RD1        (rd1),
    .RD2        (rd2),
    .RD3        (rd3),
    .ResultW    (result),
    .WriteCount (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        we;
    logic        mtr;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic [31:0] res;
    logic [31:0] rb;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic m,
                       input logic [31:0] d, input logic [31:0] x,
                       input logic [4:0] r, input logic [4:0] p1,
                       input logic [4:0] p2, input logic [4:0] p3);
    we = w; mtr = m; rdata = d; alu = x;
    wr = r; a1 = p1; a2 = p2; a3 = p3;
  endtask

  function automatic logic [31:0] m_result();
    return mtr ? rdata : alu;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a,
                                         input bit port_byp);
    if (a == 5'd0) return 32'h0;
    if (port_byp && BYP && rst_n && we && wr != 5'd0 && a == wr)
      return m_result();
    return m_reg[a];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    m_cnt = 32'h0;
  endtask

  // one rising edge applied to the model, then back to the falling edge
  task automatic tick();
    @(posedge clk);
    if (rst_n && we && wr != 5'd0) begin
      m_reg[wr] = m_result();
      m_cnt     = m_cnt + 32'd1;
    end
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h0000AAAA, 32'h00000042, 5'd8,
                32'h00000042, 32'h00000042, 32'd1};
    vecs[1] = '{1'b1, 1'b1, 32'hCAFEF00D, 32'h00000001, 5'd31,
                32'hCAFEF00D, 32'hCAFEF00D, 32'd2};
    vecs[2] = '{1'b1, 1'b0, 32'h12345678, 32'hFFFFFFFF, 5'd0,
                32'hFFFFFFFF, 32'h00000000, 32'd2};
    vecs[3] = '{1'b0, 1'b0, 32'h0, 32'h00000055, 5'd8,
                32'h00000055, 32'h00000042, 32'd2};
    vecs[4] = '{1'b1, 1'b1, 32'h00001234, 32'h00000099, 5'd8,
                32'h00001234, 32'h00001234, 32'd3};
    vecs[5] = '{1'b1, 1'b0, 32'h0, 32'h00000077, 5'd8,
                32'h00000077, 32'h00000077, 32'd4};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd8, 5'd31, 5'd5);
    m_clear();
    @(negedge clk);
    @(negedge clk);
    check("reset_count", count, 32'h0);
    check("reset_rd1", rd1, 32'h0);
    check("reset_rd2", rd2, 32'h0);
    check("reset_rd3", rd3, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].we, vecs[i].mtr, vecs[i].rdata, vecs[i].alu,
            vecs[i].wr, 5'd0, vecs[i].wr, vecs[i].wr);
      #1;
      check($sformatf("vec%0d_result", i), result, vecs[i].res);
      tick();
      we = 1'b0;
      #1;
      check($sformatf("vec%0d_rd3", i), rd3, vecs[i].rb);
      check($sformatf("vec%0d_rd2", i), rd2, vecs[i].rb);
      check($sformatf("vec%0d_rd1_r0", i), rd1, 32'h0);
      check($sformatf("vec%0d_count", i), count, vecs[i].cnt);
    end

    // collision between a commit and a decode read of the same index
    drive(1'b1, 1'b0, 32'h0, 32'h00000011, 5'd3, 5'd3, 5'd3, 5'd3);
    tick();
    drive(1'b1, 1'b0, 32'h0, 32'h00000022, 5'd3, 5'd3, 5'd3, 5'd3);
    #1;
    check("coll_rd1_pre", rd1, BYP ? 32'h22 : 32'h11);
    check("coll_rd2_pre", rd2, BYP ? 32'h22 : 32'h11);
    check("coll_rd3_pre", rd3, 32'h11);
    tick();
    we = 1'b0;
    #1;
    check("coll_rd1_post", rd1, 32'h22);
    check("coll_rd3_post", rd3, 32'h22);

    // asynchronous reset mid-cycle after loading r5
    drive(1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5, 5'd5);
    tick();
    we = 1'b0;
    #1;
    check("r5_loaded", rd1, 32'hDEADBEEF);
    #1;
    rst_n = 1'b0;
    m_clear();
    #1;
    check("async_rst_rd1", rd1, 32'h0);
    check("async_rst_rd3", rd3, 32'h0);
    check("async_rst_count", count, 32'h0);
    drive(1'b1, 1'b1, 32'h0000005A, 32'h0000A5A5, 5'd7, 5'd7, 5'd7, 5'd7);
    #1;
    check("rst_result_mux", result, 32'h0000005A);
    check("rst_no_bypass", rd1, 32'h0);
    tick();
    we = 1'b0;
    #1;
    check("rst_write_dropped", rd3, 32'h0);
    check("rst_count_held", count, 32'h0);
    rst_n = 1'b1;
    we = 1'b1;
    tick();
    we = 1'b0;
    #1;
    check("post_rst_commit", rd3, 32'h0000005A);
    check("post_rst_count", count, 32'd1);

    // count wrap via a deposit into the counter
    dut.write_count <= 32'hFFFFFFFF;
    m_cnt = 32'hFFFFFFFF;
    drive(1'b1, 1'b0, 32'h0, 32'h00000001, 5'd1, 5'd0, 5'd0, 5'd1);
    #1;
    check("wrap_pre", count, 32'hFFFFFFFF);
    tick();
    we = 1'b0;
    #1;
    check("wrap_count", count, 32'h0);
    check("wrap_r1", rd3, 32'h1);

    // random traffic against the model
    for (int n = 0; n < 500; n++) begin
      logic [4:0] r;
      r = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
      drive(($urandom_range(0, 3) != 0), 1'($urandom), $urandom, $urandom, r,
            ($urandom_range(0, 1) == 1) ? r : 5'($urandom_range(0, 7)),
            ($urandom_range(0, 1) == 1) ? r : 5'($urandom_range(0, 7)),
            ($urandom_range(0, 1) == 1) ? r : 5'($urandom_range(0, 7)));
      #1;
      check("rnd_result", result, m_result());
      check("rnd_rd1", rd1, m_read(a1, 1'b1));
      check("rnd_rd2", rd2, m_read(a2, 1'b1));
      check("rnd_rd3", rd3, m_read(a3, 1'b0));
      check("rnd_count", count, m_cnt);
      tick();
    end

    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      a3 = 5'(i);
      #1;
      check($sformatf("final_r%0d", i), rd3, m_read(5'(i), 1'b0));
    end
    check("final_count", count, m_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
